// File: rtl/usb_rx_pkg.sv
// -----------------------------------------------------------------------------
// usb_rx_pkg
// Shared types and defaults for the full-speed USB receive front end.
//   line_t      : classified bus state ({dp,dn}: 10=J, 01=K, 00=SE0, 11=SE1)
//   rx_state_t  : framing state of the receiver
//   *_DEF       : default parameter values used by usb_nrzi_rx / usb_line_sampler
//   line_classify / line_vote : helpers shared by the sampler
// -----------------------------------------------------------------------------
package usb_rx_pkg;

  typedef enum logic [1:0] {
    LINE_J,
    LINE_K,
    LINE_SE0,
    LINE_SE1
  } line_t;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    PAYLOAD,
    EOP1,
    EOP2,
    ERROR
  } rx_state_t;

  localparam int OVERSAMPLE_DEF     = 4;
  localparam int STUFF_LIMIT_DEF    = 6;
  localparam int BUS_RESET_CLKS_DEF = 360000;
  localparam int SYNC_KJ_MIN_DEF    = 3;

  function automatic line_t line_classify(input logic dp, input logic dn);
    case ({dp, dn})
      2'b10:   return LINE_J;
      2'b01:   return LINE_K;
      2'b00:   return LINE_SE0;
      default: return LINE_SE1;
    endcase
  endfunction

  // 2-of-3 majority; three distinct values are treated as SE0 so that an
  // ambiguous bit pushes the framer towards EOP/error handling rather than data.
  function automatic line_t line_vote(input line_t a, input line_t b, input line_t c);
    if ((a == b) || (a == c)) return a;
    if (b == c)               return b;
    return LINE_SE0;
  endfunction

endpackage

// File: rtl/usb_line_sampler.sv
// -----------------------------------------------------------------------------
// usb_line_sampler
// Pad-side half of the receiver: 2-flop synchronisers on dp/dn, line
// classification, edge-locked phase counter and bit sample strobe.
// Optional build macro: USB_RX_MAJORITY_VOTE_EN (3-sample majority vote).
//
// Ports
//   clk48     in   48 MHz clock
//   reset_n   in   asynchronous active-low reset
//   dp, dn    in   raw bus lines (asynchronous)
//   line_now  out  classified synchronised line, every cycle
//   line_smp  out  line state of the current bit, qualified by smp_vld
//   smp_vld   out  one strobe per bit time at the sample point
// -----------------------------------------------------------------------------
module usb_line_sampler
  import usb_rx_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic  clk48,
  input  logic  reset_n,
  input  logic  dp,
  input  logic  dn,
  output line_t line_now,
  output line_t line_smp,
  output logic  smp_vld
);

  localparam int              PH_W    = $clog2(OVERSAMPLE);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2);

  logic            dp_p0, dp_p1;
  logic            dn_p0, dn_p1;
  line_t           line_p2;
  logic [PH_W-1:0] ph_q;
  logic [PH_W-1:0] ph;
  logic            jk_edge;

  // Stage p0/p1: synchroniser; p2: previous synchronised line for edge detect
  always_ff @(posedge clk48 or negedge reset_n) begin
    if (!reset_n) begin
      dp_p0   <= 1'b0;
      dp_p1   <= 1'b0;
      dn_p0   <= 1'b0;
      dn_p1   <= 1'b0;
      line_p2 <= LINE_SE0;
      ph_q    <= '0;
    end else begin
      dp_p0   <= dp;
      dp_p1   <= dp_p0;
      dn_p0   <= dn;
      dn_p1   <= dn_p0;
      line_p2 <= line_now;
      ph_q    <= (ph == PH_LAST) ? '0 : ph + 1'b1;
    end
  end

  assign line_now = line_classify(dp_p1, dn_p1);

  // Only data transitions re-lock the phase; SE0/SE1 entry and exit do not,
  // so EOP symbols keep the phase established by the last J/K edge.
  assign jk_edge = ((line_now == LINE_J) && (line_p2 == LINE_K)) ||
                   ((line_now == LINE_K) && (line_p2 == LINE_J));

  // The edge cycle itself counts as phase 0, so the sample lands OVERSAMPLE/2
  // cycles after the transition, in the middle of the bit.
  assign ph = jk_edge ? '0 : ph_q;

`ifdef USB_RX_MAJORITY_VOTE_EN
  localparam logic [PH_W-1:0] PH_EARLY = PH_W'(OVERSAMPLE / 2 - 1);
  localparam logic [PH_W-1:0] PH_LATE  = PH_W'(OVERSAMPLE / 2 + 1);

  line_t vote_early;
  line_t vote_mid;

  // Capture the two earlier votes; the third is the live line at PH_LATE
  always_ff @(posedge clk48 or negedge reset_n) begin
    if (!reset_n) begin
      vote_early <= LINE_SE0;
      vote_mid   <= LINE_SE0;
    end else begin
      if (ph == PH_EARLY) vote_early <= line_now;
      if (ph == PH_MID)   vote_mid   <= line_now;
    end
  end

  assign line_smp = line_vote(vote_early, vote_mid, line_now);
  assign smp_vld  = (ph == PH_LATE);
`else
  assign line_smp = line_now;
  assign smp_vld  = (ph == PH_MID);
`endif

endmodule

// File: rtl/usb_nrzi_rx.sv
// -----------------------------------------------------------------------------
// usb_nrzi_rx
// Full-speed USB receive front end: pad sampling (usb_line_sampler), NRZI
// decode, bit unstuffing with stuff-error detection, SYNC/EOP framing and
// bus-reset detection. Feeds the packet deserialiser.
// Optional build macro: USB_RX_MAJORITY_VOTE_EN (passed through to the
// sampler; adds one cycle of latency to every strobe).
//
// Ports
//   clk48      in   48 MHz clock
//   reset_n    in   asynchronous active-low reset
//   dp, dn     in   raw D+/D- (asynchronous)
//   bit_out    out  decoded bit (1 = no transition), qualified by bit_valid
//   bit_valid  out  one strobe per unstuffed payload bit
//   bus_sop    out  pulse when SYNC completes
//   bus_eop    out  pulse on a valid SE0,SE0,J end of packet
//   stuff_err  out  pulse on a bit-stuff violation
//   rx_active  out  high from bus_sop until EOP or error
//   bus_reset  out  level, high while SE0 has lasted BUS_RESET_CLKS cycles
// -----------------------------------------------------------------------------
module usb_nrzi_rx
  import usb_rx_pkg::*;
#(
  parameter int OVERSAMPLE     = OVERSAMPLE_DEF,
  parameter int STUFF_LIMIT    = STUFF_LIMIT_DEF,
  parameter int BUS_RESET_CLKS = BUS_RESET_CLKS_DEF,
  parameter int SYNC_KJ_MIN    = SYNC_KJ_MIN_DEF
) (
  input  logic clk48,
  input  logic reset_n,
  input  logic dp,
  input  logic dn,
  output logic bit_out,
  output logic bit_valid,
  output logic bus_sop,
  output logic bus_eop,
  output logic stuff_err,
  output logic rx_active,
  output logic bus_reset
);

  localparam int               RUN_W   = $clog2(STUFF_LIMIT + 1);
  localparam int               KJ_W    = $clog2(SYNC_KJ_MIN + 2);
  localparam int               CNT_W   = $clog2(BUS_RESET_CLKS + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUFF_LIMIT);
  localparam logic [KJ_W-1:0]  KJ_MIN  = KJ_W'(SYNC_KJ_MIN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUS_RESET_CLKS);

  function automatic logic [CNT_W-1:0] se0_sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [KJ_W-1:0] kj_sat_inc(input logic [KJ_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  line_t            line_now;
  line_t            line_smp;
  logic             smp_vld;

  rx_state_t        state_q, state_d;
  line_t            prev_q, prev_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [KJ_W-1:0]  kj_q, kj_d;
  logic [2:0]       jcnt_q, jcnt_d;
  logic             se0_seen_q, se0_seen_d;
  logic [CNT_W-1:0] se0_cnt_q;

  logic             line_jk;
  logic             nrzi_bit;
  logic             sync_done;
  logic             stuff_pos;
  logic             err_exit;

  logic             bit_out_d, bit_valid_d, bus_sop_d, bus_eop_d;
  logic             stuff_err_d, rx_active_d;

  usb_line_sampler #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_sampler (
    .clk48    (clk48),
    .reset_n  (reset_n),
    .dp       (dp),
    .dn       (dn),
    .line_now (line_now),
    .line_smp (line_smp),
    .smp_vld  (smp_vld)
  );

  assign line_jk   = (line_smp == LINE_J) || (line_smp == LINE_K);
  assign nrzi_bit  = (line_smp == prev_q);
  // SYNC ends on its closing KK; the first K of that pair is already in prev_q
  assign sync_done = (line_smp == LINE_K) && (prev_q == LINE_K) && (kj_q >= KJ_MIN);
  assign stuff_pos = (run_q == RUN_MAX);
  // Leave ERROR on an EOP-like SE0->J return, or on the 8th J in a row
  assign err_exit  = (line_smp == LINE_J) && (se0_seen_q || (jcnt_q == 3'd7));

  // Framer state register
  always_ff @(posedge clk48 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      prev_q     <= LINE_J;
      run_q      <= '0;
      kj_q       <= '0;
      jcnt_q     <= '0;
      se0_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      run_q      <= run_d;
      kj_q       <= kj_d;
      jcnt_q     <= jcnt_d;
      se0_seen_q <= se0_seen_d;
    end
  end

  // Framer next state; everything advances only on sample strobes
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    run_d      = run_q;
    kj_d       = kj_q;
    jcnt_d     = jcnt_q;
    se0_seen_d = se0_seen_q;
    if (smp_vld) begin
      se0_seen_d = (line_smp == LINE_SE0);
      case (state_q)
        IDLE: begin
          // The K that opens SYNC is decoded against the idle J
          if (line_smp == LINE_K) begin
            state_d = SYNC;
            prev_d  = LINE_K;
            kj_d    = '0;
          end
        end
        SYNC: begin
          if (!line_jk) begin
            state_d = IDLE;
          end else if (line_smp != prev_q) begin
            kj_d   = kj_sat_inc(kj_q);
            prev_d = line_smp;
          end else if (sync_done) begin
            state_d = PAYLOAD;
            run_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
        PAYLOAD: begin
          // SE0 is tested first so an EOP at a stuff position is not an error
          if (line_smp == LINE_SE0) begin
            state_d = EOP1;
          end else if (line_smp == LINE_SE1) begin
            state_d = ERROR;
          end else begin
            prev_d = line_smp;
            if (stuff_pos) begin
              if (nrzi_bit) state_d = ERROR;
              else          run_d   = '0;
            end else begin
              run_d = nrzi_bit ? run_q + 1'b1 : '0;
            end
          end
        end
        EOP1: state_d = (line_smp == LINE_SE0) ? EOP2 : ERROR;
        EOP2: state_d = (line_smp == LINE_J) ? IDLE : ERROR;
        ERROR: begin
          if (err_exit) begin
            state_d = IDLE;
            jcnt_d  = '0;
          end else if (line_smp == LINE_J) begin
            jcnt_d = jcnt_q + 1'b1;
          end else begin
            jcnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Framer outputs (registered below, so they appear the cycle after the sample)
  always_comb begin
    bit_out_d   = nrzi_bit;
    bit_valid_d = 1'b0;
    bus_sop_d   = 1'b0;
    bus_eop_d   = 1'b0;
    stuff_err_d = 1'b0;
    if (smp_vld) begin
      case (state_q)
        SYNC:    bus_sop_d = sync_done;
        PAYLOAD: begin
          if (line_jk) begin
            if (stuff_pos) stuff_err_d = nrzi_bit;
            else           bit_valid_d = 1'b1;
          end
        end
        EOP2:    bus_eop_d = (line_smp == LINE_J);
        default: ;
      endcase
    end
    rx_active_d = (state_d == PAYLOAD) || (state_d == EOP1) || (state_d == EOP2);
  end

  // Output stage
  always_ff @(posedge clk48 or negedge reset_n) begin
    if (!reset_n) begin
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      bus_sop   <= 1'b0;
      bus_eop   <= 1'b0;
      stuff_err <= 1'b0;
      rx_active <= 1'b0;
    end else begin
      bit_out   <= bit_out_d;
      bit_valid <= bit_valid_d;
      bus_sop   <= bus_sop_d;
      bus_eop   <= bus_eop_d;
      stuff_err <= stuff_err_d;
      rx_active <= rx_active_d;
    end
  end

  // SE0 duration counter, independent of the framer state
  always_ff @(posedge clk48 or negedge reset_n) begin
    if (!reset_n) begin
      se0_cnt_q <= '0;
    end else if (line_now == LINE_SE0) begin
      se0_cnt_q <= se0_sat_inc(se0_cnt_q);
    end else begin
      se0_cnt_q <= '0;
    end
  end

  assign bus_reset = (se0_cnt_q == CNT_MAX);

endmodule

// File: tb/tb_usb_nrzi_rx.sv
module tb_usb_nrzi_rx;

  localparam int OS    = 4;
  localparam int STUFF = 6;
  localparam int BRC   = 200;

  localparam logic [1:0] SYM_J   = 2'b10;
  localparam logic [1:0] SYM_K   = 2'b01;
  localparam logic [1:0] SYM_SE0 = 2'b00;

  logic clk48   = 1'b0;
  logic reset_n = 1'b0;
  logic dp      = 1'b1;
  logic dn      = 1'b0;
  logic bit_out, bit_valid, bus_sop, bus_eop, stuff_err, rx_active, bus_reset;

  always #10 clk48 = ~clk48;

  usb_nrzi_rx #(
    .OVERSAMPLE     (OS),
    .STUFF_LIMIT    (STUFF),
    .BUS_RESET_CLKS (BRC),
    .SYNC_KJ_MIN    (3)
  ) dut (
    .clk48     (clk48),
    .reset_n   (reset_n),
    .dp        (dp),
    .dn        (dn),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .bus_sop   (bus_sop),
    .bus_eop   (bus_eop),
    .stuff_err (stuff_err),
    .rx_active (rx_active),
    .bus_reset (bus_reset)
  );

  int checks = 0;
  int errors = 0;

  // Monitor: collect decoded bits and pulse counts; count protocol violations
  int n_sop = 0, n_eop = 0, n_serr = 0, n_bad = 0;
  bit rx_q[$];

  always @(negedge clk48) begin
    if (bit_valid) rx_q.push_back(bit_out);
    if (bus_sop)   n_sop++;
    if (bus_eop)   n_eop++;
    if (stuff_err) n_serr++;
    if ((bit_valid && !rx_active) || (bus_sop && !rx_active) ||
        (bus_eop && rx_active) || (stuff_err && rx_active) ||
        (bus_sop && bit_valid))
      n_bad++;
  end

  int b_sop, b_eop, b_serr, b_bad, b_rx;
  bit pl_q[$];
  logic [1:0] sym_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    b_sop  = n_sop;
    b_eop  = n_eop;
    b_serr = n_serr;
    b_bad  = n_bad;
    b_rx   = rx_q.size();
  endtask

  task automatic drive(input logic [1:0] v, input int n);
    {dp, dn} = v;
    repeat (n) @(posedge clk48);
    #1;
  endtask

  task automatic load_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) pl_q.push_back(b[i]);
  endtask

  // Reference encoder: SYNC, NRZI payload (optionally stuffed), EOP, idle J
  task automatic encode(input bit do_stuff);
    logic [1:0] level;
    int ones;
    sym_q.delete();
    sym_q.push_back(SYM_K); sym_q.push_back(SYM_J);
    sym_q.push_back(SYM_K); sym_q.push_back(SYM_J);
    sym_q.push_back(SYM_K); sym_q.push_back(SYM_J);
    sym_q.push_back(SYM_K); sym_q.push_back(SYM_K);
    level = SYM_K;
    ones  = 0;
    foreach (pl_q[i]) begin
      if (pl_q[i]) ones++;
      else begin level = ~level; ones = 0; end
      sym_q.push_back(level);
      if (do_stuff && ones == STUFF) begin
        level = ~level;
        sym_q.push_back(level);
        ones = 0;
      end
    end
    sym_q.push_back(SYM_SE0); sym_q.push_back(SYM_SE0);
    repeat (4) sym_q.push_back(SYM_J);
  endtask

  // Send the first nsym symbols at num/den clk48 cycles per bit
  task automatic send(input int num, input int den, input int nsym);
    for (int k = 0; k < nsym && k < sym_q.size(); k++)
      drive(sym_q[k], ((k + 1) * num) / den - (k * num) / den);
  endtask

  function automatic logic [63:0] rx_bits();
    logic [63:0] v = '0;
    for (int i = 0; (i < rx_q.size() - b_rx) && (i < 64); i++) v[i] = rx_q[b_rx + i];
    return v;
  endfunction

  function automatic logic [63:0] pl_bits();
    logic [63:0] v = '0;
    for (int i = 0; (i < pl_q.size()) && (i < 64); i++) v[i] = pl_q[i];
    return v;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    {dp, dn} = SYM_J;
    reset_n  = 1'b0;
    repeat (3) @(posedge clk48);
    #1;
    check("reset_outputs", {bit_out, bit_valid, bus_sop, bus_eop, stuff_err, rx_active, bus_reset}, 0);
    reset_n = 1'b1;
    drive(SYM_J, 20);
    check("idle_outputs", {bit_valid, bus_sop, bus_eop, stuff_err, rx_active, bus_reset}, 0);

    // Byte 0xA5 at exactly 4 cycles per bit
    pl_q.delete();
    load_byte(8'hA5);
    encode(1'b1);
    mark();
    send(4, 1, sym_q.size());
    drive(SYM_J, 12);
    check("a5_count", rx_q.size() - b_rx, 8);
    check("a5_bits", rx_bits(), 64'hA5);
    check("a5_sop", n_sop - b_sop, 1);
    check("a5_eop", n_eop - b_eop, 1);
    check("a5_serr", n_serr - b_serr, 0);
    check("a5_protocol", n_bad - b_bad, 0);

    // Seven ones with the stuffed zero after the sixth
    pl_q.delete();
    repeat (7) pl_q.push_back(1'b1);
    encode(1'b1);
    mark();
    send(4, 1, sym_q.size());
    drive(SYM_J, 12);
    check("stuff_count", rx_q.size() - b_rx, 7);
    check("stuff_bits", rx_bits(), 64'h7F);
    check("stuff_serr", n_serr - b_serr, 0);
    check("stuff_eop", n_eop - b_eop, 1);

    // Seven ones with no stuffed transition -> stuff error, recover via EOP
    pl_q.delete();
    repeat (7) pl_q.push_back(1'b1);
    pl_q.push_back(1'b0); pl_q.push_back(1'b1); pl_q.push_back(1'b0);
    encode(1'b0);
    mark();
    send(4, 1, sym_q.size());
    drive(SYM_J, 12);
    check("viol_count", rx_q.size() - b_rx, 6);
    check("viol_bits", rx_bits(), 64'h3F);
    check("viol_serr", n_serr - b_serr, 1);
    check("viol_eop", n_eop - b_eop, 0);
    check("viol_protocol", n_bad - b_bad, 0);
    check("viol_active", rx_active, 0);

    // 64 random bits at 3.9 and 4.1 cycles per bit
    for (int r = 0; r < 2; r++) begin
      pl_q.delete();
      repeat (64) pl_q.push_back(1'($urandom_range(0, 1)));
      encode(1'b1);
      mark();
      send((r == 0) ? 39 : 41, 10, sym_q.size());
      drive(SYM_J, 12);
      check("drift_count", rx_q.size() - b_rx, 64);
      check("drift_bits", rx_bits(), pl_bits());
      check("drift_eop", n_eop - b_eop, 1);
      check("drift_serr", n_serr - b_serr, 0);
    end

    // Bus reset: SE0 for BRC cycles plus synchroniser latency
    drive(SYM_J, 10);
    {dp, dn} = SYM_SE0;
    repeat (BRC + 1) @(posedge clk48);
    #1;
    check("busrst_early", bus_reset, 0);
    @(posedge clk48); #1;
    check("busrst_rise", bus_reset, 1);
    repeat (30) @(posedge clk48);
    #1;
    check("busrst_hold", bus_reset, 1);
    {dp, dn} = SYM_J;
    @(posedge clk48); #1;
    {dp, dn} = SYM_SE0;
    @(posedge clk48); #1;
    check("busrst_sync_lat", bus_reset, 1);
    @(posedge clk48); #1;
    check("busrst_clear", bus_reset, 0);
    drive(SYM_J, 20);

    // Reset mid-payload, then a clean packet
    pl_q.delete();
    repeat (16) pl_q.push_back(1'($urandom_range(0, 1)));
    encode(1'b1);
    send(4, 1, 18);
    check("midrst_active_before", rx_active, 1);
    reset_n = 1'b0;
    #1;
    check("midrst_outputs", {bit_out, bit_valid, bus_sop, bus_eop, stuff_err, rx_active, bus_reset}, 0);
    drive(SYM_J, 5);
    reset_n = 1'b1;
    drive(SYM_J, 20);
    pl_q.delete();
    load_byte(8'h3C);
    load_byte(8'($urandom_range(0, 255)));
    encode(1'b1);
    mark();
    send(4, 1, sym_q.size());
    drive(SYM_J, 12);
    check("after_rst_count", rx_q.size() - b_rx, 16);
    check("after_rst_bits", rx_bits(), pl_bits());
    check("after_rst_sop", n_sop - b_sop, 1);
    check("after_rst_eop", n_eop - b_eop, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
